// File: rtl/upsample_module.sv
// rtl/upsample_module.sv - 2x nearest-neighbour upsampler with a single-row replay buffer
module upsample_module #(
    parameter int DW      = 8,
    parameter int CH      = 16,
    parameter int MAX_COL = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_en,
    input  logic             start,
    input  logic [15:0]      col,
    input  logic [15:0]      row,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW*CH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW*CH-1:0] data_out,
    output logic             up_end,
    output logic             busy
);
    localparam int          W    = DW * CH;
    localparam int          AW   = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
    localparam logic [15:0] MAXC = 16'(MAX_COL);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FIRST  = 2'd1;
    localparam logic [1:0] S_SECOND = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]   state;
    logic         p;
    logic [15:0]  c;
    logic [15:0]  col_r;
    logic [15:0]  row_r;
    logic [15:0]  rcnt;
    logic [W-1:0] hold;
    logic [W-1:0] out_q;
    logic         out_v;
    logic         up_end_q;
    logic         busy_q;
    logic [W-1:0] lbuf [MAX_COL];

    logic         slot_free;
    logic         last_col;
    logic         load;
    logic [W-1:0] load_data;
    logic         in_ready_up;

    assign slot_free   = !out_v || out_ready;
    assign last_col    = (c == col_r - 16'd1);
    assign in_ready_up = (state == S_FIRST) && !p && slot_free;

    always_comb begin
        load      = 1'b0;
        load_data = out_q;
        case (state)
            S_FIRST: begin
                if (!p) begin
                    load      = in_valid && slot_free;
                    load_data = data_in;
                end else begin
                    load      = slot_free;
                    load_data = hold;
                end
            end
            S_SECOND: begin
                load      = slot_free;
                load_data = lbuf[c[AW-1:0]];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            p        <= 1'b0;
            c        <= '0;
            col_r    <= '0;
            row_r    <= '0;
            rcnt     <= '0;
            hold     <= '0;
            out_q    <= '0;
            out_v    <= 1'b0;
            up_end_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            up_end_q <= 1'b0;
            if (load) begin
                out_q <= load_data;
                out_v <= 1'b1;
            end else if (slot_free) begin
                out_v <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start && up_en) begin
                        col_r <= (col > MAXC) ? MAXC : col;
                        row_r <= row;
                        c     <= '0;
                        p     <= 1'b0;
                        rcnt  <= '0;
                        // Empty frames complete immediately without ever raising busy
                        if (col == 16'd0 || row == 16'd0) begin
                            up_end_q <= 1'b1;
                        end else begin
                            busy_q <= 1'b1;
                            state  <= S_FIRST;
                        end
                    end
                end
                S_FIRST: begin
                    if (!p) begin
                        if (in_valid && slot_free) begin
                            hold <= data_in;
                            p    <= 1'b1;
                        end
                    end else if (slot_free) begin
                        p <= 1'b0;
                        if (last_col) begin
                            c     <= '0;
                            state <= S_SECOND;
                        end else begin
                            c <= c + 16'd1;
                        end
                    end
                end
                S_SECOND: begin
                    if (slot_free) begin
                        p <= !p;
                        if (p) begin
                            if (last_col) begin
                                c    <= '0;
                                rcnt <= rcnt + 16'd1;
                                state <= (rcnt + 16'd1 < row_r) ? S_FIRST : S_DRAIN;
                            end else begin
                                c <= c + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    if (out_v && out_ready) begin
                        up_end_q <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_FIRST && !p && in_valid && slot_free)
            lbuf[c[AW-1:0]] <= data_in;
    end

    assign in_ready  = up_en ? in_ready_up : out_ready;
    assign out_valid = up_en ? out_v       : in_valid;
    assign data_out  = up_en ? out_q       : data_in;
    assign up_end    = up_en && up_end_q;
    assign busy      = up_en && busy_q;
endmodule

// File: doc/upsample_module.md
Name: upsample_module

Overview:
- 2x nearest-neighbour upsampler (unpooling) for the CNN datapath; the inverse of the 2x2 max-pool stage.
- Consumes a feature-map row stream of CH 8-bit channels per beat, col beats per row, row rows per frame.
- Emits each pixel twice horizontally and each row twice vertically.
- A single-row line buffer replays rows; valid/ready handshakes on both sides; up_end marks frame completion.

Parameters:
- DW, 8, bits per channel (unsigned).
- CH, 16, channels per beat.
- MAX_COL, 64, line-buffer depth; largest supported input row width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- up_en  in  1  1 = upsample, 0 = bypass; static for a whole frame.
- start  in  1  one-cycle pulse that begins a frame; ignored when busy=1.
- col  in  16  input row width in beats; sampled on start.
- row  in  16  input rows per frame; sampled on start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- data_in  in  DW*CH  input pixel; channel k at bits [DW*k +: DW].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- data_out  out  DW*CH  output pixel.
- up_end  out  1  one-cycle pulse at end of frame.
- busy  out  1  high from start until up_end.

Behaviour:
- Reset (synchronous, rst_n=0 at clk edge): state=IDLE, out_valid=0, data_out=0, up_end=0, busy=0, all counters and the phase bit cleared. Line-buffer contents are don't-care. A reset mid-frame aborts the frame with no up_end.
- Sampling on start: col_r=min(col, MAX_COL), row_r=row. If col=0 or row=0, up_end pulses the next cycle, no beats are produced, and the block returns to IDLE.
- Output stage: one register (data_out, out_valid).
  - The slot is free when !out_valid | out_ready.
  - On a load, out_valid=1 and data_out=new value. If the slot is free and nothing loads, out_valid goes to 0.
  - data_out is held stable while out_valid & !out_ready.
- State FIRST (first copy of an input row):
  - Phase bit p; column counter c.
  - p=0: in_ready = slot free. On accept: out reg <= data_in, lbuf[c] <= data_in, hold <= data_in, p <= 1.
  - p=1: in_ready=0. When the slot is free: out reg <= hold, p <= 0, c <= c+1.
  - When c reaches col_r-1 and the p=1 load occurs: c <= 0, go to SECOND.
- State SECOND (vertical repeat of the same row):
  - in_ready=0. lbuf is read combinationally at index c.
  - When the slot is free: out reg <= lbuf[c] and p toggles; c increments when p goes 1->0.
  - After the second copy of lbuf[col_r-1] is loaded: rcnt <= rcnt+1, then go to FIRST if rcnt+1 < row_r, else go to DRAIN.
- State DRAIN: wait for the final out_valid & out_ready handshake. In the next cycle: up_end=1, busy=0, state=IDLE.
- Output ordering and count:
  - Per input row P0..P(col-1), output is P0,P0,P1,P1,...,P(col-1),P(col-1), then that sequence again.
  - Frame total = 4*col_r*row_r beats.
  - Sustained throughput is 1 output beat per cycle with out_ready=1; the input side runs at 1 beat per 4 cycles on average.
- Latency: an accepted input beat appears on data_out in the next cycle.
- Boundaries:
  - col=1: each row yields 4 identical beats.
  - col=MAX_COL: c wraps to 0 with no overflow.
  - col>MAX_COL: clamped to MAX_COL; excess input beats are never accepted.
  - A start pulse while busy=1 is ignored.
- Bypass (up_en=0), combinational pass-through:
  - data_out=data_in, out_valid=in_valid, in_ready=out_ready.
  - up_end=0 and busy=0; start is ignored.

Test Plan:
- col=2, row=1, inputs A,B, out_ready=1 -> out A,A,B,B,A,A,B,B on consecutive cycles once inputs are available; up_end pulses 1 cycle after the 8th beat; busy falls with it.
- col=3, row=2, inputs 1..6, out_ready=1 -> 24 beats: 1,1,2,2,3,3 twice, then 4,4,5,5,6,6 twice; in_ready=0 throughout each SECOND phase.
- Same as test 1, but out_ready pattern 1,0,0,1,... -> data_out is held stable during every stall; the output sequence is identical; no beat is lost or duplicated beyond the specified 2x.
- start with col=0, row=5 -> no out_valid, in_ready stays 0, up_end=1 exactly one cycle later.
- up_en=0, in_valid=1, data_in=0x55..55, out_ready=0 -> out_valid=1, data_out=0x55..55, in_ready=0, up_end=0.
- rst_n=0 during the SECOND state of a col=4 frame -> next cycle out_valid=0, busy=0, no up_end; a fresh start with col=1, row=1 then yields 4 beats and up_end.
